// File: rtl/softmax_row_serializer_pkg.sv
// rtl/softmax_row_serializer_pkg.sv - shared attention Q-format widths, serializer FSM encoding, index-width helper
// Optional feature macro used by importers: SOFTMAX_SER_ROW_SUM_EN
package softmax_row_serializer_pkg;

  localparam int ATTN_ELEM_W = 16;
  localparam int ATTN_FRAC_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Index counter width; a one-element row still needs a 1-bit index port
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/softmax_row_sum_acc.sv
// rtl/softmax_row_sum_acc.sv - clear/add/commit row-sum accumulator
// Instantiated by softmax_row_serializer only when SOFTMAX_SER_ROW_SUM_EN is defined.
module softmax_row_sum_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int SUM_WIDTH  = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  add_en,
  input  logic [DATA_WIDTH-1:0] add_data,
  input  logic                  commit,
  output logic                  sum_valid,
  output logic [SUM_WIDTH-1:0]  sum_data
);

  logic [SUM_WIDTH-1:0] acc_q, acc_d, acc_sum;
  logic [SUM_WIDTH-1:0] sum_data_q, sum_data_d;
  logic                 sum_valid_q, sum_valid_d;

  always_comb begin
    acc_sum     = acc_q + SUM_WIDTH'(add_data);
    acc_d       = acc_q;
    sum_data_d  = sum_data_q;
    sum_valid_d = 1'b0;
    if (add_en) begin
      acc_d = acc_sum;
      if (commit) begin
        sum_data_d  = acc_sum;
        sum_valid_d = 1'b1;
      end
    end
    // A new row captured on the last beat starts from zero after the commit
    if (clear) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sum_data_q  <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sum_data_q  <= sum_data_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum_valid = sum_valid_q;
  assign sum_data  = sum_data_q;

endmodule

// File: rtl/softmax_row_serializer.sv
// rtl/softmax_row_serializer.sv - buffers one packed softmax row and streams it one element per cycle
// Optional row-sum output enabled by SOFTMAX_SER_ROW_SUM_EN.
module softmax_row_serializer
  import softmax_row_serializer_pkg::*;
#(
  parameter  int DATA_WIDTH  = ATTN_ELEM_W,
  parameter  int DATA_LENGTH = 4,
  localparam int IDX_WIDTH   = idx_width(DATA_LENGTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*DATA_LENGTH-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [IDX_WIDTH-1:0]              out_idx,
  output logic                              out_last,
  output logic                              sum_valid,
  output logic [DATA_WIDTH+IDX_WIDTH:0]     sum_data
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_LENGTH - 1);

  ser_state_e                        state_q, state_d;
  logic [DATA_WIDTH*DATA_LENGTH-1:0] buf_q, buf_d;
  logic [IDX_WIDTH-1:0]              idx_q, idx_d;
  logic                              in_fire, out_fire;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      if (idx_q == IDX_WIDTH'(i)) begin
        out_data = buf_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_valid = (state_q == ST_SEND);
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == LAST_IDX);
  // Accepting on the last beat is what removes the bubble between rows
  assign in_ready  = (state_q == ST_IDLE) || (out_last && out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          buf_d   = in_data;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_fire) begin
          if (!out_last) begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end else if (in_fire) begin
            buf_d = in_data;
            idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
    end
  end

`ifdef SOFTMAX_SER_ROW_SUM_EN
  softmax_row_sum_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .SUM_WIDTH  (DATA_WIDTH + IDX_WIDTH + 1)
  ) u_sum_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (in_fire),
    .add_en    (out_fire),
    .add_data  (out_data),
    .commit    (out_last),
    .sum_valid (sum_valid),
    .sum_data  (sum_data)
  );
`else
  assign sum_valid = 1'b0;
  assign sum_data  = '0;
`endif

endmodule
